// File: rtl/merge_pass_sequencer.sv
// Multi-pass scheduler for the merger-tree sort kernel.
// Issues num_pass merge passes, ping-ponging between out and tmp buffers.
module merge_pass_sequencer #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_XFER_SIZE_WIDTH = 64,
  parameter int C_LOG2_LEAVES     = 5,
  parameter int C_INIT_RUN_BYTES  = 64
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         ap_start,
  input  logic [7:0]                   num_pass,
  input  logic [C_XFER_SIZE_WIDTH-1:0] xfer_size_in_bytes,
  input  logic [C_ADDR_WIDTH-1:0]      in_addr_offset,
  input  logic [C_ADDR_WIDTH-1:0]      out_addr_offset,
  input  logic [C_ADDR_WIDTH-1:0]      tmp_addr_offset,
  input  logic                         pass_done,
  output logic                         pass_start,
  output logic [C_ADDR_WIDTH-1:0]      pass_rd_addr,
  output logic [C_ADDR_WIDTH-1:0]      pass_wr_addr,
  output logic [C_XFER_SIZE_WIDTH-1:0] pass_run_bytes,
  output logic [C_XFER_SIZE_WIDTH-1:0] pass_size,
  output logic [7:0]                   pass_idx,
  output logic                         busy,
  output logic                         ap_done
);

  localparam int XW = C_XFER_SIZE_WIDTH;
  localparam int RW = C_XFER_SIZE_WIDTH + C_LOG2_LEAVES;
  localparam logic [XW-1:0] LP_INIT = XW'(C_INIT_RUN_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]              r_num_pass;
  logic [XW-1:0]           r_size;
  logic [C_ADDR_WIDTH-1:0] r_in;
  logic [C_ADDR_WIDTH-1:0] r_out;
  logic [C_ADDR_WIDTH-1:0] r_tmp;
  logic [C_ADDR_WIDTH-1:0] r_rd;
  logic [C_ADDR_WIDTH-1:0] r_wr;
  logic [XW-1:0]           r_run;
  logic [7:0]              r_idx;
  logic                    r_wr_out;

  logic          w_zero;
  logic          w_last;
  logic [RW-1:0] w_run_wide;
  logic [RW-1:0] w_size_wide;
  logic [XW-1:0] w_run_next;
  logic [XW-1:0] w_run_init;

  assign w_zero = (r_num_pass == 8'd0) || (r_size == '0);
  assign w_last = (r_idx == (r_num_pass - 8'd1));

  // Widened shift so a run near the top of the range cannot wrap.
  assign w_run_wide  = {{C_LOG2_LEAVES{1'b0}}, r_run} << C_LOG2_LEAVES;
  assign w_size_wide = {{C_LOG2_LEAVES{1'b0}}, r_size};
  assign w_run_next  = (w_run_wide > w_size_wide) ?
                       r_size : w_run_wide[XW-1:0];
  assign w_run_init  = (r_size < LP_INIT) ? r_size : LP_INIT;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (ap_start) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_next = w_zero ? S_FINISH : S_ISSUE;
      end
      S_ISSUE: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (pass_done) w_next = w_last ? S_FINISH : S_ISSUE;
      end
      S_FINISH: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_num_pass <= '0;
      r_size     <= '0;
      r_in       <= '0;
      r_out      <= '0;
      r_tmp      <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_run      <= '0;
      r_idx      <= '0;
      r_wr_out   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ap_start) begin
            r_num_pass <= num_pass;
            r_size     <= xfer_size_in_bytes;
            r_in       <= in_addr_offset;
            r_out      <= out_addr_offset;
            r_tmp      <= tmp_addr_offset;
          end
        end
        S_LOAD: begin
          if (!w_zero) begin
            // Odd pass count means pass 0 already targets out.
            r_idx    <= 8'd0;
            r_rd     <= r_in;
            r_run    <= w_run_init;
            r_wr_out <= r_num_pass[0];
            r_wr     <= r_num_pass[0] ? r_out : r_tmp;
          end
        end
        S_WAIT: begin
          if (pass_done && !w_last) begin
            r_idx    <= r_idx + 8'd1;
            r_rd     <= r_wr;
            r_wr_out <= ~r_wr_out;
            r_wr     <= r_wr_out ? r_tmp : r_out;
            r_run    <= w_run_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign pass_start     = (r_state == S_ISSUE);
  assign ap_done        = (r_state == S_FINISH);
  assign busy           = (r_state != S_IDLE);
  assign pass_rd_addr   = r_rd;
  assign pass_wr_addr   = r_wr;
  assign pass_run_bytes = r_run;
  assign pass_size      = r_size;
  assign pass_idx       = r_idx;

endmodule

// File: tb/tb_merge_pass_sequencer.sv
// Randomized and directed bench for merge_pass_sequencer.
// Expected pass lists come from a parity/arithmetic model of the schedule.
module tb_merge_pass_sequencer;

  logic        aclk = 1'b0;
  logic        areset;
  logic        ap_start;
  logic [7:0]  num_pass;
  logic [63:0] xfer_size_in_bytes;
  logic [63:0] in_addr_offset;
  logic [63:0] out_addr_offset;
  logic [63:0] tmp_addr_offset;
  logic        pass_done;
  logic        pass_start;
  logic [63:0] pass_rd_addr;
  logic [63:0] pass_wr_addr;
  logic [63:0] pass_run_bytes;
  logic [63:0] pass_size;
  logic [7:0]  pass_idx;
  logic        busy;
  logic        ap_done;

  int n_cmp = 0;
  int n_err = 0;
  int last_idx = 0;

  logic [63:0] e_rd[$];
  logic [63:0] e_wr[$];
  logic [63:0] e_run[$];

  merge_pass_sequencer dut (
    .aclk               (aclk),
    .areset             (areset),
    .ap_start           (ap_start),
    .num_pass           (num_pass),
    .xfer_size_in_bytes (xfer_size_in_bytes),
    .in_addr_offset     (in_addr_offset),
    .out_addr_offset    (out_addr_offset),
    .tmp_addr_offset    (tmp_addr_offset),
    .pass_done          (pass_done),
    .pass_start         (pass_start),
    .pass_rd_addr       (pass_rd_addr),
    .pass_wr_addr       (pass_wr_addr),
    .pass_run_bytes     (pass_run_bytes),
    .pass_size          (pass_size),
    .pass_idx           (pass_idx),
    .busy               (busy),
    .ap_done            (ap_done)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic build(input int np, input logic [63:0] size,
                       input logic [63:0] ia, input logic [63:0] oa,
                       input logic [63:0] ta);
    logic [127:0] run;
    logic [63:0]  prev_wr;
    e_rd.delete();
    e_wr.delete();
    e_run.delete();
    run = (size < 64) ? {64'd0, size} : 128'd64;
    prev_wr = ia;
    for (int k = 0; k < np; k++) begin
      logic [63:0] wr;
      wr = (((np - 1 - k) % 2) == 0) ? oa : ta;
      e_rd.push_back(k == 0 ? ia : prev_wr);
      e_wr.push_back(wr);
      e_run.push_back(run[63:0]);
      prev_wr = wr;
      run = run * 32;
      if (run > {64'd0, size}) run = {64'd0, size};
    end
  endtask

  task automatic scramble();
    num_pass           = 8'($urandom);
    xfer_size_in_bytes = {$urandom, $urandom};
    in_addr_offset     = {$urandom, $urandom};
    out_addr_offset    = {$urandom, $urandom};
    tmp_addr_offset    = {$urandom, $urandom};
  endtask

  task automatic kick(input int np, input logic [63:0] size,
                      input logic [63:0] ia, input logic [63:0] oa,
                      input logic [63:0] ta);
    @(negedge aclk);
    ap_start           = 1'b1;
    num_pass           = 8'(np);
    xfer_size_in_bytes = size;
    in_addr_offset     = ia;
    out_addr_offset    = oa;
    tmp_addr_offset    = ta;
    @(negedge aclk);
    ap_start = 1'b0;
    scramble();
  endtask

  task automatic run_job(input int np, input logic [63:0] size,
                         input logic [63:0] ia, input logic [63:0] oa,
                         input logic [63:0] ta, input int dly,
                         input bit spur_issue, input bit spur_start);
    build(np, size, ia, oa, ta);
    kick(np, size, ia, oa, ta);
    chk("busy_load", busy, 1);
    chk("start_load", pass_start, 0);
    if (np == 0 || size == 0) begin
      @(negedge aclk);
      chk("zero_done", ap_done, 1);
      chk("zero_nostart", pass_start, 0);
      chk("zero_busy", busy, 1);
      @(negedge aclk);
      chk("zero_done_clr", ap_done, 0);
      chk("zero_busy_clr", busy, 0);
      return;
    end
    @(negedge aclk);
    for (int k = 0; k < np; k++) begin
      chk($sformatf("start_p%0d", k), pass_start, 1);
      chk($sformatf("idx_p%0d", k), pass_idx, k);
      chk($sformatf("rd_p%0d", k), pass_rd_addr, e_rd[k]);
      chk($sformatf("wr_p%0d", k), pass_wr_addr, e_wr[k]);
      chk($sformatf("run_p%0d", k), pass_run_bytes, e_run[k]);
      chk($sformatf("size_p%0d", k), pass_size, size);
      chk($sformatf("wr_not_in_p%0d", k), pass_wr_addr != ia, 1);
      if (spur_issue && k == 0) pass_done = 1'b1;
      for (int d = 0; d < dly; d++) begin
        @(negedge aclk);
        pass_done = 1'b0;
        ap_start  = (spur_start && k == 0 && d == 2);
        if (d == 0) begin
          chk($sformatf("wait_nostart_p%0d", k), pass_start, 0);
          chk($sformatf("wait_busy_p%0d", k), busy, 1);
        end
      end
      ap_start = 1'b0;
      chk($sformatf("hold_rd_p%0d", k), pass_rd_addr, e_rd[k]);
      chk($sformatf("hold_wr_p%0d", k), pass_wr_addr, e_wr[k]);
      chk($sformatf("hold_run_p%0d", k), pass_run_bytes, e_run[k]);
      chk($sformatf("hold_idx_p%0d", k), pass_idx, k);
      chk($sformatf("hold_nodone_p%0d", k), ap_done, 0);
      pass_done = 1'b1;
      @(negedge aclk);
      pass_done = 1'b0;
    end
    chk("done_pulse", ap_done, 1);
    chk("done_busy", busy, 1);
    chk("done_nostart", pass_start, 0);
    @(negedge aclk);
    chk("done_clr", ap_done, 0);
    chk("busy_clr", busy, 0);
    chk("idle_nostart", pass_start, 0);
    last_idx = np - 1;
  endtask

  initial begin
    areset    = 1'b1;
    ap_start  = 1'b0;
    pass_done = 1'b0;
    scramble();
    #3;
    chk("rst_start", pass_start, 0);
    chk("rst_done", ap_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd", pass_rd_addr, 0);
    chk("rst_wr", pass_wr_addr, 0);
    chk("rst_run", pass_run_bytes, 0);
    chk("rst_size", pass_size, 0);
    chk("rst_idx", pass_idx, 0);
    @(negedge aclk);
    areset = 1'b0;

    // Directed plan cases
    run_job(3, 64'd4096, 64'h1000, 64'h8000, 64'h20000, 10, 0, 0);
    run_job(2, 64'd4096, 64'h1000, 64'h8000, 64'h20000, 10, 0, 0);
    run_job(0, 64'd4096, 64'h1000, 64'h8000, 64'h20000, 10, 0, 0);
    run_job(5, 64'd0, 64'h1000, 64'h8000, 64'h20000, 10, 0, 0);

    // pass_done while idle must do nothing
    @(negedge aclk);
    pass_done = 1'b1;
    @(negedge aclk);
    pass_done = 1'b0;
    chk("idle_done_busy", busy, 0);
    chk("idle_done_start", pass_start, 0);
    @(negedge aclk);
    chk("idle_done_busy2", busy, 0);
    chk("idle_done_start2", pass_start, 0);

    // pass_done in ISSUE cycle and ap_start in WAIT are ignored
    run_job(3, 64'd4096, 64'h1000, 64'h8000, 64'h20000, 6, 1, 1);

    // Asynchronous reset during WAIT of pass 1 of 3
    build(3, 64'd4096, 64'h1000, 64'h8000, 64'h20000);
    kick(3, 64'd4096, 64'h1000, 64'h8000, 64'h20000);
    @(negedge aclk);
    chk("rstm_p0_start", pass_start, 1);
    repeat (4) @(negedge aclk);
    pass_done = 1'b1;
    @(negedge aclk);
    pass_done = 1'b0;
    chk("rstm_p1_start", pass_start, 1);
    chk("rstm_p1_rd", pass_rd_addr, e_rd[1]);
    repeat (2) @(negedge aclk);
    #2;
    areset = 1'b1;
    #1;
    chk("rstm_start", pass_start, 0);
    chk("rstm_done", ap_done, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_rd", pass_rd_addr, 0);
    chk("rstm_wr", pass_wr_addr, 0);
    chk("rstm_run", pass_run_bytes, 0);
    chk("rstm_size", pass_size, 0);
    chk("rstm_idx", pass_idx, 0);
    @(negedge aclk);
    areset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("rstm_after_done", ap_done, 0);
      chk("rstm_after_start", pass_start, 0);
    end
    run_job(3, 64'd4096, 64'h1000, 64'h8000, 64'h20000, 3, 0, 0);

    // Run-length saturation at 2^63
    run_job(16, 64'h8000_0000_0000_0000, 64'h100, 64'h200, 64'h300,
            1, 0, 0);

    // Randomized jobs
    for (int j = 0; j < 10; j++) begin
      int          np;
      int          sel;
      logic [63:0] sz;
      logic [63:0] ia;
      logic [63:0] oa;
      logic [63:0] ta;
      np  = $urandom_range(0, 6);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       sz = 64'($urandom_range(1, 63));
        1:       sz = 64'($urandom_range(64, 1 << 20));
        2:       sz = {$urandom, $urandom};
        default: sz = 64'($urandom_range(0, 1));
      endcase
      ia = {$urandom, $urandom};
      oa = ia + 64'h1_0000_0000;
      ta = ia + 64'h2_0000_0000;
      run_job(np, sz, ia, oa, ta, $urandom_range(1, 12), 0, 0);
    end

    // Idle index stays at the last pass of the previous job
    @(negedge aclk);
    chk("final_busy", busy, 0);
    if (last_idx >= 0) chk("final_idx_hold", pass_idx, last_idx);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/merge_pass_sequencer.md
# merge_pass_sequencer

Multi-pass scheduler for the merger-tree sort kernel. It sits between the kernel control logic (ap_start/ap_done) and the merger-tree datapath. On one start pulse it issues `num_pass` merge passes back-to-back. Each pass gets its own read base, write base and input run length, and the sequencer waits for the datapath's completion pulse before issuing the next pass. Buffers ping-pong between the output and scratch regions so the final pass always lands at `out_addr_offset` and the input buffer is never overwritten.

## Interface
Parameters:
- C_ADDR_WIDTH, 64, address width of all base addresses.
- C_XFER_SIZE_WIDTH, 64, width of byte counts and run lengths.
- C_LOG2_LEAVES, 5, log2 of merger-tree leaf count; 32 leaves, so run length grows ×32 per pass.
- C_INIT_RUN_BYTES, 64, run length in bytes entering pass 0 (one presorted 512-bit beat).

Ports:
- aclk  in  1  kernel clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- ap_start  in  1  single-cycle start pulse.
- num_pass  in  8  number of passes to run.
- xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  total data size.
- in_addr_offset  in  C_ADDR_WIDTH  source buffer; read-only.
- out_addr_offset  in  C_ADDR_WIDTH  destination buffer.
- tmp_addr_offset  in  C_ADDR_WIDTH  scratch buffer, same size as the data.
- pass_done  in  1  datapath pulse: the current pass is fully written back.
- pass_start  out  1  single-cycle pulse that launches a pass.
- pass_rd_addr  out  C_ADDR_WIDTH  read base of the current pass.
- pass_wr_addr  out  C_ADDR_WIDTH  write base of the current pass.
- pass_run_bytes  out  C_XFER_SIZE_WIDTH  input run length of the current pass.
- pass_size  out  C_XFER_SIZE_WIDTH  bytes in the current pass; equals the latched size.
- pass_idx  out  8  index of the current pass, 0-based.
- busy  out  1  high from start acceptance until ap_done.
- ap_done  out  1  single-cycle completion pulse.

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, FINISH.
- IDLE:
  - On ap_start, latch num_pass, size and the three addresses.
  - Set busy and go to LOAD.
  - ap_start in any other state is ignored.
- LOAD:
  - If latched num_pass==0 or size==0, go to FINISH; no pass is issued.
  - Otherwise set pass_idx=0, pass_rd_addr=in, pass_run_bytes=min(C_INIT_RUN_BYTES, size).
  - Set pass_wr_addr = out if (num_pass−1) is even, else tmp.
  - Go to ISSUE.
- ISSUE: assert pass_start for one cycle, then go to WAIT.
- WAIT:
  - Hold all pass_* fields stable.
  - On pass_done with pass_idx==num_pass−1, go to FINISH.
  - On pass_done otherwise:
    - pass_idx+1.
    - pass_rd_addr ← previous pass_wr_addr.
    - pass_wr_addr ← other of {out, tmp}.
    - pass_run_bytes ← run<<C_LOG2_LEAVES, clamped to size.
    - Go to ISSUE.
- Write-buffer rule: pass k writes out when (num_pass−1−k) is even, else tmp. The last pass therefore always writes out.
- FINISH: pulse ap_done for one cycle, clear busy, go to IDLE.
- Run-length arithmetic:
  - Evaluate the shift at C_XFER_SIZE_WIDTH+C_LOG2_LEAVES bits, then compare against size; this guarantees no wrap-around.
  - Once a run reaches size, it stays at size.
- pass_done outside WAIT is ignored (no queueing).
- areset mid-operation: immediately return to IDLE and clear all outputs. No pass_start or ap_done pulse follows.

## Timing
- Reset values: every output 0; state IDLE; internal latches 0.
- ap_start sampled at edge T:
  - LOAD at T+1.
  - pass_start high during cycle T+2, with pass_* fields already valid in that cycle.
- pass_done sampled high at edge D in WAIT:
  - Next pass_start at D+1, with updated fields.
  - For the last pass, ap_done is high during D+1 and busy drops at D+2.
- Zero work (num_pass==0 or size==0): ap_done high during T+2; no pass_start.
- Minimum gap between pass_start pulses is 2 cycles.
- ap_done and a new ap_start in the same cycle: ap_start is ignored (state is FINISH, not IDLE).
- busy is high from T+1 through the ap_done cycle inclusive.

## Test plan
- Three passes, normal sequence.
  - Stimulus: num_pass=3, size=4096, in=0x1000, out=0x8000, tmp=0x20000; pass_done 10 cycles after each pass_start.
  - Required: three pass_start pulses, with rd/wr = 0x1000→0x8000, 0x8000→0x20000, 0x20000→0x8000.
  - Required: run lengths 64, 2048, 4096 (65536 clamped); ap_done once; pass_idx 0,1,2.
- Two passes, even count.
  - Stimulus: num_pass=2, same addresses.
  - Required: pass 0 goes 0x1000→0x20000, pass 1 goes 0x20000→0x8000; the input buffer is never a write target.
- Zero work.
  - Stimulus: num_pass=0 with size=4096, then num_pass=5 with size=0.
  - Required: in each case no pass_start, ap_done exactly 2 cycles after ap_start, busy high for 2 cycles.
- Spurious inputs.
  - Stimulus: pass_done pulsed in IDLE and in the ISSUE cycle; ap_start pulsed during WAIT.
  - Required: no state change, no extra pass, fields unchanged.
- Reset mid-pass.
  - Stimulus: areset asserted asynchronously during WAIT of pass 1 of 3.
  - Required: all outputs 0 in the same cycle, no ap_done. A fresh ap_start afterwards restarts from pass_idx=0 with rd=in.
- Run-length saturation.
  - Stimulus: size=2^63, num_pass=16.
  - Required: pass_run_bytes grows ×32 per pass and clamps to 2^63 without wrapping to a smaller value.
